// File: rtl/mem_access_stage.sv
// MEM stage of the 16-bit core: issues one data-memory load/store per instruction over a
// ready handshake, stalls upstream while the access is outstanding, and registers MEM/WB fields.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        regWrite,
    input  logic        r0Write,
    input  logic        memSource,
    input  logic [3:0]  RA1,
    input  logic [15:0] ALUResult,
    input  logic [15:0] storeData,
    input  logic [15:0] R0D,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall_o,
    output logic        valid_o,
    output logic        regWrite_o,
    output logic        r0Write_o,
    output logic        memSource_o,
    output logic [3:0]  RA1_o,
    output logic [15:0] ALUResult_o,
    output logic [15:0] DataIn_o,
    output logic [15:0] R0D_o,
    output logic        err_o
);

    // state  | meaning
    // IDLE   | accepting instructions, pass-through ops complete in one cycle
    // ACCESS | memory request outstanding, upstream stalled
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d, we_q, we_d, ld_q, ld_d;
    logic [15:0]      addr_q, addr_d, wdata_q, wdata_d;
    logic             rw_q, rw_d, r0w_q, r0w_d, ms_q, ms_d;
    logic [3:0]       ra1_q, ra1_d;
    logic [15:0]      r0d_q, r0d_d;
    logic             vld_q, vld_d, rw_out_q, rw_out_d, r0w_out_q, r0w_out_d, ms_out_q, ms_out_d;
    logic [3:0]       ra1_out_q, ra1_out_d;
    logic [15:0]      alu_out_q, alu_out_d, din_out_q, din_out_d, r0d_out_q, r0d_out_d;
    logic             err_q, err_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        ld_d      = ld_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        r0w_d     = r0w_q;
        ms_d      = ms_q;
        ra1_d     = ra1_q;
        r0d_d     = r0d_q;
        vld_d     = 1'b0;
        rw_out_d  = 1'b0;
        r0w_out_d = 1'b0;
        ms_out_d  = ms_out_q;
        ra1_out_d = ra1_out_q;
        alu_out_d = alu_out_q;
        din_out_d = din_out_q;
        r0d_out_d = r0d_out_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (valid_i && (memRead || memWrite)) begin
                    // memRead together with memWrite is handled as a store
                    state_d = ACCESS;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = memWrite;
                    ld_d    = ~memWrite;
                    addr_d  = ALUResult;
                    wdata_d = storeData;
                    rw_d    = regWrite;
                    r0w_d   = r0Write;
                    ms_d    = memSource;
                    ra1_d   = RA1;
                    r0d_d   = R0D;
                end else if (valid_i) begin
                    vld_d     = 1'b1;
                    rw_out_d  = regWrite;
                    r0w_out_d = r0Write;
                    ms_out_d  = memSource;
                    ra1_out_d = RA1;
                    alu_out_d = ALUResult;
                    din_out_d = '0;
                    r0d_out_d = R0D;
                end
            end
            ACCESS: begin
                if (mem_ready || cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    vld_d     = 1'b1;
                    ms_out_d  = ms_q;
                    ra1_out_d = ra1_q;
                    alu_out_d = addr_q;
                    r0d_out_d = r0d_q;
                    if (mem_ready) begin
                        rw_out_d  = rw_q;
                        r0w_out_d = r0w_q;
                        din_out_d = ld_q ? mem_rdata : 16'h0000;
                    end else begin
                        din_out_d = '0;
                        err_d     = 1'b1;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            ld_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            r0w_q     <= 1'b0;
            ms_q      <= 1'b0;
            ra1_q     <= '0;
            r0d_q     <= '0;
            vld_q     <= 1'b0;
            rw_out_q  <= 1'b0;
            r0w_out_q <= 1'b0;
            ms_out_q  <= 1'b0;
            ra1_out_q <= '0;
            alu_out_q <= '0;
            din_out_q <= '0;
            r0d_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            ld_q      <= ld_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            r0w_q     <= r0w_d;
            ms_q      <= ms_d;
            ra1_q     <= ra1_d;
            r0d_q     <= r0d_d;
            vld_q     <= vld_d;
            rw_out_q  <= rw_out_d;
            r0w_out_q <= r0w_out_d;
            ms_out_q  <= ms_out_d;
            ra1_out_q <= ra1_out_d;
            alu_out_q <= alu_out_d;
            din_out_q <= din_out_d;
            r0d_out_q <= r0d_out_d;
            err_q     <= err_d;
        end
    end

    assign stall_o     = (state_q == ACCESS);
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign valid_o     = vld_q;
    assign regWrite_o  = rw_out_q;
    assign r0Write_o   = r0w_out_q;
    assign memSource_o = ms_out_q;
    assign RA1_o       = ra1_out_q;
    assign ALUResult_o = alu_out_q;
    assign DataIn_o    = din_out_q;
    assign R0D_o       = r0d_out_q;
    assign err_o       = err_q;

endmodule
